fetch_stage_ctrl: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter and the IF/ID pipeline register, and applies the stall and flush controls issued by the hazard detection unit (PC_Write, IF_ID_Write, IF_Flush, PCSrc). It drives the instruction-memory address and captures the returned instruction into IF/ID for the decode stage. It also keeps saturating stall and flush event counters for pipeline performance measurement.

---
 rtl/fetch_stage_ctrl.sv | 77 +++++++
 tb/tb_fetch_stage_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register, and
// saturating stall/flush event counters driven by the hazard unit controls.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 PC_Write,
  input  logic                 IF_ID_Write,
  input  logic                 IF_Flush,
  input  logic                 PCSrc,
  input  logic [31:0]          Branch_Target,
  input  logic [31:0]          IM_Instr,
  output logic [31:0]          IM_Addr,
  output logic [31:0]          IF_ID_PC4,
  output logic [31:0]          IF_ID_Instr,
  output logic                 IF_ID_Valid,
  output logic [CNT_WIDTH-1:0] Stall_Count,
  output logic [CNT_WIDTH-1:0] Flush_Count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall_evt;

  always_comb begin
    pc_plus4  = pc + 32'd4;
    stall_evt = !PC_Write && !PCSrc;
  end

  // A redirect always wins over a stall so a taken branch is never lost.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pc <= {RESET_PC[31:2], 2'b00};
    end else if (PCSrc) begin
      pc <= {Branch_Target[31:2], 2'b00};
    end else if (PC_Write) begin
      pc <= pc_plus4;
    end
  end

  assign IM_Addr = pc;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_PC4   <= '0;
      IF_ID_Instr <= '0;
      IF_ID_Valid <= 1'b0;
    end else if (IF_Flush) begin
      IF_ID_PC4   <= '0;
      IF_ID_Instr <= '0;
      IF_ID_Valid <= 1'b0;
    end else if (IF_ID_Write) begin
      IF_ID_PC4   <= pc_plus4;
      IF_ID_Instr <= IM_Instr;
      IF_ID_Valid <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (stall_evt && (Stall_Count != '1)) begin
        Stall_Count <= Stall_Count + CNT_ONE;
      end
      if (IF_Flush && (Flush_Count != '1)) begin
        Flush_Count <= Flush_Count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed plus randomized bench for fetch_stage_ctrl against a cycle-level
// reference model of PC, IF/ID and the saturating event counters.
module tb_fetch_stage_ctrl;

  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          PC_Write, IF_ID_Write, IF_Flush, PCSrc;
  logic [31:0]   Branch_Target;
  logic [31:0]   IM_Instr;
  logic [31:0]   IM_Addr, IF_ID_PC4, IF_ID_Instr;
  logic          IF_ID_Valid;
  logic [CW-1:0] Stall_Count, Flush_Count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int          m_stall, m_flush;

  always #5 clk_i = ~clk_i;

  fetch_stage_ctrl #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(CW)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .PC_Write     (PC_Write),
    .IF_ID_Write  (IF_ID_Write),
    .IF_Flush     (IF_Flush),
    .PCSrc        (PCSrc),
    .Branch_Target(Branch_Target),
    .IM_Instr     (IM_Instr),
    .IM_Addr      (IM_Addr),
    .IF_ID_PC4    (IF_ID_PC4),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_Valid  (IF_ID_Valid),
    .Stall_Count  (Stall_Count),
    .Flush_Count  (Flush_Count)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign IM_Instr = mem_rd(IM_Addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_stall = 0; m_flush = 0;
  endtask

  // Applies the inputs present at the edge to the model's pre-edge state.
  task automatic model_edge();
    logic [31:0] nxt_pc;
    if (PCSrc)         nxt_pc = Branch_Target & 32'hFFFF_FFFC;
    else if (PC_Write) nxt_pc = m_pc + 32'd4;
    else               nxt_pc = m_pc;
    if (IF_Flush) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (IF_ID_Write) begin
      m_instr = mem_rd(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end
    if (!PC_Write && !PCSrc) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
    if (IF_Flush)            m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
    m_pc = nxt_pc;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  IM_Addr,            m_pc);
    check({tag, ".pc4"},   IF_ID_PC4,          m_pc4);
    check({tag, ".instr"}, IF_ID_Instr,        m_instr);
    check({tag, ".valid"}, 32'(IF_ID_Valid),   32'(m_valid));
    check({tag, ".stall"}, 32'(Stall_Count),   32'(m_stall));
    check({tag, ".flush"}, 32'(Flush_Count),   32'(m_flush));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_i);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_ctrl(input logic pw, input logic iw, input logic fl,
                          input logic ps, input logic [31:0] bt);
    PC_Write = pw; IF_ID_Write = iw; IF_Flush = fl; PCSrc = ps; Branch_Target = bt;
  endtask

  initial begin
    rst_n = 1'b0;
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    model_reset();
    #12;
    check_all("reset");
    check("reset.addr_const", IM_Addr, 32'h0);
    rst_n = 1'b1;

    // Straight-line fetch, then a 2-cycle load-use stall at PC=8.
    cycle("seq0");
    check("seq0.addr_const",  IM_Addr,     32'h4);
    check("seq0.instr_const", IF_ID_Instr, 32'h11);
    cycle("seq1");
    check("seq1.addr_const",  IM_Addr,     32'h8);
    check("seq1.instr_const", IF_ID_Instr, 32'h22);
    check("seq1.pc4_const",   IF_ID_PC4,   32'h8);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle("stall0");
    cycle("stall1");
    check("stall.addr_const",  IM_Addr,             32'h8);
    check("stall.instr_const", IF_ID_Instr,         32'h22);
    check("stall.count_const", 32'(Stall_Count),    32'd2);
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle("resume");
    check("resume.addr_const",  IM_Addr,     32'hC);
    check("resume.instr_const", IF_ID_Instr, 32'h33);
    check("resume.pc4_const",   IF_ID_PC4,   32'hC);

    // Taken branch with flush.
    set_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 32'h43);
    cycle("branch");
    check("branch.addr_const",  IM_Addr,             32'h40);
    check("branch.valid_const", 32'(IF_ID_Valid),    32'h0);
    check("branch.flush_const", 32'(Flush_Count),    32'd1);
    check("branch.stall_const", 32'(Stall_Count),    32'd2);
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle("target");
    check("target.instr_const", IF_ID_Instr, mem_rd(32'h40));

    // All controls asserted together.
    set_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    cycle("simul");
    check("simul.addr_const",  IM_Addr,          32'h80);
    check("simul.stall_const", 32'(Stall_Count), 32'd2);

    // PC wrap at the top of the address space.
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle("wrap0");
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle("wrap1");
    check("wrap.addr_const", IM_Addr,   32'h0);
    check("wrap.pc4_const",  IF_ID_PC4, 32'h0);

    // Counter saturation.
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) cycle("sat");
    check("sat.count_const", 32'(Stall_Count), 32'hF);

    // Asynchronous reset in the middle of a fetch cycle.
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle("pre_areset");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("areset");
    check("areset.addr_const", IM_Addr, 32'h0);
    #2 rst_n = 1'b1;
    cycle("post_areset");

    // Randomized control streams, every combination legal at the ports.
    for (int i = 0; i < 400; i++) begin
      set_ctrl($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
